// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - shared state encoding and constants for the memory bus arbiter
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bus_state_e;

    localparam int MAX_BUS_WIDTH = 64;

    // Returned to the requester when memory never answers; sliced to BUS_WIDTH.
    localparam logic [MAX_BUS_WIDTH-1:0] TIMEOUT_READ_DATA = {MAX_BUS_WIDTH{1'b1}};

    function automatic int count_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - wait-cycle counter; expired flags the last allowed cycle
module bus_timeout_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    // A limit of zero never expires.
    assign expired = enable && (limit != '0) && (count == limit - WIDTH'(1));

endmodule

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - shares one memory port between a pulsed controller and a level core
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 360
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel_core,
    output logic                 owner,
    output logic                 busy,
    input  logic                 ctrl_read,
    input  logic                 ctrl_write,
    input  logic [BUS_WIDTH-1:0] ctrl_address,
    input  logic [BUS_WIDTH-1:0] ctrl_write_data,
    output logic                 ctrl_response,
    output logic [BUS_WIDTH-1:0] ctrl_read_data,
    input  logic                 core_read,
    input  logic                 core_write,
    input  logic [BUS_WIDTH-1:0] core_address,
    input  logic [BUS_WIDTH-1:0] core_write_data,
    output logic                 core_response,
    output logic [BUS_WIDTH-1:0] core_read_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_write_data,
    input  logic [BUS_WIDTH-1:0] mem_read_data,
    input  logic                 mem_response,
    output logic                 timeout_error,
    output logic                 ctrl_overrun,
    input  logic                 error_clear
);

    localparam int                   CNT_W = count_width(TIMEOUT_CYCLES);
    localparam logic [BUS_WIDTH-1:0] FILL  = TIMEOUT_READ_DATA[BUS_WIDTH-1:0];

    bus_state_e           state;
    logic                 pend_valid;
    logic                 pend_write;
    logic [BUS_WIDTH-1:0] pend_addr;
    logic [BUS_WIDTH-1:0] pend_data;
    logic                 txn_core;
    logic                 expired;

    logic ctrl_req, eligible, issue, pend_take, latch_free, capture, overrun_evt;
    logic mem_done, timeout_evt;
    logic [BUS_WIDTH-1:0] result;

    assign ctrl_req    = ctrl_read | ctrl_write;
    assign eligible    = owner ? (core_read | core_write) : pend_valid;
    assign issue       = (state == IDLE) && eligible;
    assign pend_take   = issue && !owner;
    // The latch may refill on the same edge its current entry is issued.
    assign latch_free  = !pend_valid || pend_take;
    assign capture     = ctrl_req && latch_free;
    assign overrun_evt = ctrl_req && !latch_free;
    assign mem_done    = (state == WAIT) && mem_response;
    assign timeout_evt = (state == WAIT) && !mem_response && expired;
    assign result      = mem_done ? mem_read_data : FILL;

    bus_timeout_counter #(.WIDTH(CNT_W)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (issue),
        .enable  (state == WAIT),
        .limit   (CNT_W'(TIMEOUT_CYCLES)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= 1'b0;
            busy           <= 1'b0;
            pend_valid     <= 1'b0;
            pend_write     <= 1'b0;
            pend_addr      <= '0;
            pend_data      <= '0;
            txn_core       <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            ctrl_response  <= 1'b0;
            ctrl_read_data <= '0;
            core_response  <= 1'b0;
            core_read_data <= '0;
            timeout_error  <= 1'b0;
            ctrl_overrun   <= 1'b0;
        end else begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            ctrl_response <= 1'b0;
            core_response <= 1'b0;

            if (capture) begin
                pend_valid <= 1'b1;
                pend_write <= ctrl_write;
                pend_addr  <= ctrl_address;
                pend_data  <= ctrl_write_data;
            end else if (pend_take) begin
                pend_valid <= 1'b0;
            end

            ctrl_overrun  <= overrun_evt | (ctrl_overrun & ~error_clear);
            timeout_error <= timeout_evt | (timeout_error & ~error_clear);

            case (state)
                IDLE: begin
                    owner <= sel_core;
                    if (issue) begin
                        // Route the response to whoever issued, even if owner flips now.
                        txn_core       <= owner;
                        mem_address    <= owner ? core_address : pend_addr;
                        mem_write_data <= owner ? core_write_data : pend_data;
                        mem_write      <= owner ? core_write : pend_write;
                        mem_read       <= owner ? !core_write : !pend_write;
                        busy           <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done || timeout_evt) begin
                        if (txn_core) begin
                            core_read_data <= result;
                            core_response  <= 1'b1;
                        end else begin
                            ctrl_read_data <= result;
                            ctrl_response  <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - directed self-checking bench for memory_bus_arbiter
module tb_memory_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel_core = 1'b0;
    logic        owner, busy;
    logic        ctrl_read = 1'b0, ctrl_write = 1'b0;
    logic [31:0] ctrl_address = '0, ctrl_write_data = '0;
    logic        ctrl_response;
    logic [31:0] ctrl_read_data;
    logic        core_read = 1'b0, core_write = 1'b0;
    logic [31:0] core_address = '0, core_write_data = '0;
    logic        core_response;
    logic [31:0] core_read_data;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        mem_response = 1'b0;
    logic        timeout_error, ctrl_overrun;
    logic        error_clear = 1'b0;

    int checks = 0;
    int fails  = 0;

    memory_bus_arbiter #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .sel_core(sel_core), .owner(owner), .busy(busy),
        .ctrl_read(ctrl_read), .ctrl_write(ctrl_write), .ctrl_address(ctrl_address),
        .ctrl_write_data(ctrl_write_data), .ctrl_response(ctrl_response), .ctrl_read_data(ctrl_read_data),
        .core_read(core_read), .core_write(core_write), .core_address(core_address),
        .core_write_data(core_write_data), .core_response(core_response), .core_read_data(core_read_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_response(mem_response),
        .timeout_error(timeout_error), .ctrl_overrun(ctrl_overrun), .error_clear(error_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({owner, busy, mem_read, mem_write, ctrl_response, core_response, timeout_error, ctrl_overrun} !== 8'h00) begin $display("FAIL reset_flags: got %b expected 00000000", {owner, busy, mem_read, mem_write, ctrl_response, core_response, timeout_error, ctrl_overrun}); fails++; end
        checks++; if ({mem_address, mem_write_data, ctrl_read_data, core_read_data} !== 128'h0) begin $display("FAIL reset_data: got %h expected 0", {mem_address, mem_write_data, ctrl_read_data, core_read_data}); fails++; end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ctrl_write();
        mem_response = 1'b1;
        tick();
        mem_response = 1'b0;
        checks++; if ({busy, ctrl_response, core_response} !== 3'b000) begin $display("FAIL stray_response: got %b expected 000", {busy, ctrl_response, core_response}); fails++; end
        ctrl_write = 1'b1; ctrl_address = 32'h100; ctrl_write_data = 32'hCAFEF00D;
        tick();
        ctrl_write = 1'b0;
        tick();
        checks++; if ({mem_write, mem_read, busy} !== 3'b101) begin $display("FAIL wr_strobe: got %b expected 101", {mem_write, mem_read, busy}); fails++; end
        checks++; if ({mem_address, mem_write_data} !== {32'h100, 32'hCAFEF00D}) begin $display("FAIL wr_addr_data: got %h expected 00000100cafef00d", {mem_address, mem_write_data}); fails++; end
        tick();
        checks++; if (mem_write !== 1'b0) begin $display("FAIL wr_single_pulse: got %b expected 0", mem_write); fails++; end
        tick();
        mem_response = 1'b1;
        tick();
        mem_response = 1'b0;
        checks++; if ({ctrl_response, core_response} !== 2'b10) begin $display("FAIL wr_response: got %b expected 10", {ctrl_response, core_response}); fails++; end
        tick();
        checks++; if ({ctrl_response, busy, core_read_data} !== {2'b00, 32'h0}) begin $display("FAIL wr_finish: got %h expected 0", {ctrl_response, busy, core_read_data}); fails++; end
    endtask

    task automatic test_core_read();
        sel_core = 1'b1;
        tick();
        checks++; if (owner !== 1'b1) begin $display("FAIL core_owner: got %b expected 1", owner); fails++; end
        core_read = 1'b1; core_address = 32'h40;
        ctrl_read = 1'b1; ctrl_address = 32'h200;
        tick();
        ctrl_read = 1'b0;
        checks++; if ({mem_read, mem_address} !== {1'b1, 32'h40}) begin $display("FAIL core_strobe: got %h expected 100000040", {mem_read, mem_address}); fails++; end
        mem_response = 1'b1; mem_read_data = 32'h12345678;
        tick();
        mem_response = 1'b0; core_read = 1'b0;
        checks++; if ({core_response, ctrl_response, core_read_data} !== {2'b10, 32'h12345678}) begin $display("FAIL core_response: got %h expected 212345678", {core_response, ctrl_response, core_read_data}); fails++; end
        tick();
        tick();
        checks++; if ({busy, mem_read} !== 2'b00) begin $display("FAIL ctrl_held_pending: got %b expected 00", {busy, mem_read}); fails++; end
        sel_core = 1'b0;
        tick();
        checks++; if ({owner, mem_read} !== 2'b00) begin $display("FAIL ctrl_not_yet: got %b expected 00", {owner, mem_read}); fails++; end
        tick();
        checks++; if ({mem_read, mem_address} !== {1'b1, 32'h200}) begin $display("FAIL ctrl_after_switch: got %h expected 100000200", {mem_read, mem_address}); fails++; end
        mem_response = 1'b1; mem_read_data = 32'hA5A50001;
        tick();
        mem_response = 1'b0;
        checks++; if ({ctrl_response, core_response, ctrl_read_data, core_read_data} !== {2'b10, 32'hA5A50001, 32'h12345678}) begin $display("FAIL ctrl_read_route: got %h expected 2a5a5000112345678", {ctrl_response, core_response, ctrl_read_data, core_read_data}); fails++; end
        tick();
    endtask

    task automatic test_owner_switch();
        ctrl_read = 1'b1; ctrl_address = 32'h300;
        tick();
        ctrl_read = 1'b0;
        tick();
        sel_core = 1'b1;
        tick();
        tick();
        checks++; if ({owner, busy} !== 2'b01) begin $display("FAIL owner_hold_wait: got %b expected 01", {owner, busy}); fails++; end
        mem_response = 1'b1; mem_read_data = 32'h0BADBEEF;
        tick();
        mem_response = 1'b0;
        checks++; if ({owner, ctrl_response, ctrl_read_data} !== {2'b01, 32'h0BADBEEF}) begin $display("FAIL owner_hold_done: got %h expected 10badbeef", {owner, ctrl_response, ctrl_read_data}); fails++; end
        tick();
        checks++; if ({owner, busy} !== 2'b00) begin $display("FAIL owner_after_done: got %b expected 00", {owner, busy}); fails++; end
        tick();
        checks++; if (owner !== 1'b1) begin $display("FAIL owner_idle_load: got %b expected 1", owner); fails++; end
        sel_core = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int waited;
        ctrl_read = 1'b1; ctrl_address = 32'h400;
        tick();
        ctrl_read = 1'b0;
        tick();
        waited = 0;
        while (ctrl_response !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++; if (waited !== 8) begin $display("FAIL timeout_latency: got %0d cycles expected 8", waited); fails++; end
        checks++; if ({timeout_error, ctrl_read_data} !== {1'b1, 32'hFFFFFFFF}) begin $display("FAIL timeout_data: got %h expected 1ffffffff", {timeout_error, ctrl_read_data}); fails++; end
        tick();
        tick();
        checks++; if (timeout_error !== 1'b1) begin $display("FAIL timeout_sticky: got %b expected 1", timeout_error); fails++; end
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        checks++; if (timeout_error !== 1'b0) begin $display("FAIL timeout_clear: got %b expected 0", timeout_error); fails++; end
    endtask

    task automatic test_back_to_back();
        ctrl_write = 1'b1; ctrl_address = 32'h500; ctrl_write_data = 32'h1;
        tick();
        ctrl_read = 1'b1; ctrl_address = 32'h600; ctrl_write_data = 32'h2;
        tick();
        ctrl_write = 1'b0;
        checks++; if ({mem_write, mem_address} !== {1'b1, 32'h500}) begin $display("FAIL b2b_first: got %h expected 100000500", {mem_write, mem_address}); fails++; end
        ctrl_address = 32'h700;
        tick();
        ctrl_read = 1'b0;
        checks++; if (ctrl_overrun !== 1'b1) begin $display("FAIL overrun_set: got %b expected 1", ctrl_overrun); fails++; end
        mem_response = 1'b1;
        tick();
        mem_response = 1'b0;
        tick();
        checks++; if ({busy, mem_write, mem_read} !== 3'b000) begin $display("FAIL b2b_gap: got %b expected 000", {busy, mem_write, mem_read}); fails++; end
        tick();
        checks++; if ({mem_write, mem_read, mem_address, mem_write_data} !== {2'b10, 32'h600, 32'h2}) begin $display("FAIL b2b_second_write_wins: got %h expected 20000060000000002", {mem_write, mem_read, mem_address, mem_write_data}); fails++; end
        mem_response = 1'b1;
        tick();
        mem_response = 1'b0;
        tick();
        tick();
        tick();
        checks++; if ({busy, mem_read, mem_write, ctrl_overrun} !== 4'b0001) begin $display("FAIL overrun_dropped: got %b expected 0001", {busy, mem_read, mem_write, ctrl_overrun}); fails++; end
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        checks++; if (ctrl_overrun !== 1'b0) begin $display("FAIL overrun_clear: got %b expected 0", ctrl_overrun); fails++; end
    endtask

    task automatic test_reset_mid_wait();
        ctrl_read = 1'b1; ctrl_address = 32'h800;
        tick();
        ctrl_read = 1'b0;
        tick();
        checks++; if ({busy, mem_read} !== 2'b11) begin $display("FAIL rst_pre_wait: got %b expected 11", {busy, mem_read}); fails++; end
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy, mem_read, mem_address} !== {2'b00, 32'h0}) begin $display("FAIL rst_async: got %h expected 0", {busy, mem_read, mem_address}); fails++; end
        mem_response = 1'b1;
        tick();
        checks++; if ({ctrl_response, core_response} !== 2'b00) begin $display("FAIL rst_no_response: got %b expected 00", {ctrl_response, core_response}); fails++; end
        #2 reset = 1'b1;
        mem_response = 1'b0;
        tick();
        ctrl_write = 1'b1; ctrl_address = 32'h900; ctrl_write_data = 32'h5A5A5A5A;
        tick();
        ctrl_write = 1'b0;
        tick();
        checks++; if ({mem_write, mem_address, mem_write_data} !== {1'b1, 32'h900, 32'h5A5A5A5A}) begin $display("FAIL rst_next_issue: got %h expected 1000009005a5a5a5a", {mem_write, mem_address, mem_write_data}); fails++; end
        mem_response = 1'b1;
        tick();
        mem_response = 1'b0;
        checks++; if (ctrl_response !== 1'b1) begin $display("FAIL rst_next_response: got %b expected 1", ctrl_response); fails++; end
        tick();
    endtask

    initial begin
        test_reset();
        test_ctrl_write();
        test_core_read();
        test_owner_switch();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, data/address width of every bus port.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 360, memory wait limit in clk cycles; 0 disables timeout.
REQ-003 SHALL have ports: clk  in  1  single clock; reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports: sel_core  in  1  requested owner (0 controller, 1 core); owner  out  1  current owner; busy  out  1  transaction in flight.
REQ-005 SHALL have ports: ctrl_read, ctrl_write  in  1  one-cycle request pulses; ctrl_address, ctrl_write_data  in  BUS_WIDTH; ctrl_response  out  1; ctrl_read_data  out  BUS_WIDTH.
REQ-006 SHALL have ports: core_read, core_write  in  1  level requests held until core_response; core_address, core_write_data  in  BUS_WIDTH; core_response  out  1; core_read_data  out  BUS_WIDTH.
REQ-007 SHALL have ports: mem_read, mem_write  out  1; mem_address, mem_write_data  out  BUS_WIDTH; mem_read_data  in  BUS_WIDTH; mem_response  in  1.
REQ-008 SHALL have ports: timeout_error, ctrl_overrun  out  1  sticky flags; error_clear  in  1  clears both flags.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, DONE; all outputs registered.
REQ-010 owner SHALL load sel_core only on a clock edge where state is IDLE; sel_core changes during WAIT/DONE take effect on first IDLE edge.
REQ-011 A ctrl_read/ctrl_write pulse SHALL be captured (opcode, address, data) into a one-entry pending latch on the edge it is sampled, in any state.
REQ-012 A ctrl pulse arriving while the latch is full SHALL be dropped and SHALL set ctrl_overrun.
REQ-013 When read and write assert in the same cycle (either requester), write SHALL win and read SHALL be discarded.
REQ-014 In IDLE, eligible request = pending latch if owner=0, core_read|core_write if owner=1; a ctrl pending entry SHALL wait while owner=1.
REQ-015 On IDLE edge with eligible request: register mem_address/mem_write_data, assert mem_read or mem_write for exactly the next cycle, clear pending latch (ctrl), go WAIT, busy=1.
REQ-016 In WAIT, mem_response=1 (including the strobe cycle) SHALL capture mem_read_data into the owner's read_data, pulse owner's response for one cycle, go DONE.
REQ-017 DONE SHALL last one cycle, accept no request, then go IDLE with busy=0; core SHALL drop its request in the response cycle.
REQ-018 Timeout counter SHALL clear on entering WAIT, increment each WAIT cycle; on reaching TIMEOUT_CYCLES without response: set timeout_error, pulse response with read_data = all ones, go DONE.
REQ-019 mem_response outside WAIT SHALL be ignored.
REQ-020 error_clear SHALL clear flags; a set event in the same cycle SHALL take precedence.
REQ-021 Non-owner response SHALL stay 0; its read_data SHALL hold last value.
REQ-022 Back-to-back ctrl requests SHALL issue minimum 3 cycles apart (IDLE, WAIT, DONE).

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, owner 0, pending latch empty, counter 0, all strobes/responses/flags/busy 0, all data/address outputs 0.
REQ-024 Reset during WAIT SHALL abandon the transaction with no response pulse; release SHALL start in IDLE.

Structure
REQ-025 State encodings and the timeout read-data value SHALL reside in a shared package memory_bus_pkg.
REQ-026 Timeout counter SHALL be a sub-module bus_timeout_counter (clear, enable, limit, expired).

Verification
REQ-027 ctrl_write addr 0x100 data 0xCAFEF00D, mem_response 2 cycles after strobe -> one mem_write pulse with those values, ctrl_response one pulse, core signals untouched.
REQ-028 sel_core=1, core_read addr 0x40, memory returns 0x12345678 -> core_response pulse, core_read_data 0x12345678; ctrl pulse meanwhile stays pending until sel_core=0.
REQ-029 sel_core toggled to 1 during ctrl WAIT -> owner stays 0 until DONE->IDLE, ctrl_response delivered.
REQ-030 TIMEOUT_CYCLES=8, no mem_response -> response after 8 WAIT cycles, read_data 0xFFFFFFFF, timeout_error=1 until error_clear.
REQ-031 Two ctrl pulses one cycle apart while WAIT active -> first issued, second latched; third pulse before issue -> ctrl_overrun=1, dropped.
REQ-032 reset=0 mid-WAIT -> all outputs 0 immediately, no response pulse, next request serviced normally.
